esp32_rom_loader: RTL
=====================

Name: esp32_rom_loader

Overview:
- Upstream stage of the SDRAM arbitration mux in the top level: turns ESP32 SPI bus byte writes (from spi_ram_btn) into 16-bit SDRAM load words (load_wr/load_addr/load_data).
- Provides load_done, rom_type, rom_mask and ram_mask to the SNES core; it is the C_esp32_loader counterpart of the flash game_loader.
- Pairs bytes into words, buffers them in a small FIFO, and paces writes against the SDRAM busy signal.

Parameters:
- C_fifo_depth_log2, 2, log2 of word FIFO depth (4 entries).
- C_ctrl_page, 8'hFF, spi_addr[31:24] value selecting the control register.
- C_cfg_page, 8'hFE, spi_addr[31:24] value selecting the config registers.
- C_rom_page, 8'h00, spi_addr[31:24] value selecting ROM byte space.

Ports:
- clk  in  1  system clock (clk_sys domain).
- reset  in  1  asynchronous, active-high reset.
- spi_wr  in  1  SPI write strobe level from spi_ram_btn; only its rising edge is acted on.
- spi_addr  in  32  SPI byte address.
- spi_data  in  8  SPI write byte.
- ram_busy  in  1  SDRAM controller busy.
- load_wr  out  1  one-cycle SDRAM write request.
- load_addr  out  25  SDRAM byte address, always even.
- load_data  out  16  {odd byte, even byte}.
- load_done  out  1  1 = core owns SDRAM.
- rom_type  out  8  cartridge type.
- rom_mask  out  24  ROM address mask.
- ram_mask  out  24  BSRAM address mask.
- overflow  out  1  sticky FIFO-overflow flag.

Behaviour:
- Reset values: all outputs 0; FSM state IDLE; FIFO empty; pending-byte valid flag cleared.
- Write event: spi_wr is registered; an event fires when spi_wr=1 and the registered copy is 0. Event processing begins the cycle after detection.
- Control page:
  - Event with page=C_ctrl_page and spi_data[0]=1, from IDLE or DONE -> LOADING. On entry: load_done=0 next cycle; clear max_addr, overflow and pending.
  - Event with page=C_ctrl_page and spi_data[0]=0, in LOADING -> DRAIN.
  - All other control events are ignored.
- Config page (any state): spi_addr[0]=0 writes rom_type. spi_addr[0]=1 writes ram size code N; ram_mask = 0 when N=0, else (1024<<N)-1, saturating to 24'hFFFFFF for N>=14.
- ROM page, accepted only in LOADING:
  - Let a=spi_addr[23:0].
  - a[0]=0: if a byte is already pending, push {8'h00, pending byte} at the pending address, then store the new byte as pending.
  - a[0]=1: if a byte is pending at a-1, push {spi_data, pending byte} and clear pending. Otherwise push {spi_data, 8'h00} at a-1.
  - max_addr <= max(max_addr, a).
  - ROM-page events outside LOADING are ignored.
- rom_mask: right-smear of max_addr (each bit = OR of itself and all higher bits). It updates continuously during load and is held afterwards.
- FIFO: push and pop may occur in the same cycle. A push when full drops the word and sets overflow (sticky until the next LOADING entry).
- Issue path (LOADING/DRAIN):
  - When the FIFO is not empty, ram_busy=0 and guard=0: pulse load_wr for exactly one cycle, with load_addr={1'b0, entry addr[23:1], 1'b0} and load_data=entry data held stable; pop the entry.
  - guard is set for 2 cycles after each issue, so busy latency from the controller is masked.
  - A pending word is never issued while ram_busy=1.
- DRAIN: first flush any pending byte as a word, then wait until FIFO empty, guard=0 and ram_busy=0 -> DONE.
- DONE: load_done=1 and the issue path is idle.
- Reset mid-load: asynchronous return to IDLE; FIFO contents are discarded; load_wr deasserts immediately.
- Latency: with the FIFO empty and the SDRAM idle, load_wr rises 3 cycles after the spi_wr rising edge of the odd byte.

Decomposition:
- Package esp32_loader_pkg holds:
  - state enum {IDLE, LOADING, DRAIN, DONE};
  - page constants;
  - FIFO entry struct {addr[23:1], data[15:0]};
  - function ram_mask_from_code.
- Sub-module loader_word_fifo: synchronous FIFO parameterised by depth, with full/empty flags and simultaneous push/pop.

Test Plan:
- Control 0x01, then ROM bytes 0x00:0x34 and 0x01:0x12, then control 0x00 -> one load_wr with addr 0x0000000 and data 0x1234; load_done=1 after drain; rom_mask=0x000001.
- Load 512 KiB sequentially (last address 0x07FFFF), toggling ram_busy for 5 cycles after each write -> 262144 writes, no overflow, rom_mask=0x07FFFF.
- Single even byte 0x10:0xAB, then control 0x00 -> flush write at addr 0x10 with data 0x00AB, then DONE.
- Hold ram_busy=1 and send 6 word pairs -> first 4 words buffered, overflow=1 and 2 words dropped; release busy -> 4 writes occur.
- Config 0xFE000000=0x00 and 0xFE000001=0x01 -> rom_type=0x00, ram_mask=0x0007FF; code 0x0F -> ram_mask=0xFFFFFF.
- Assert reset between a push and its issue -> load_wr=0 the same cycle, load_done=0; after release, FIFO empty and state IDLE.

Source files
------------

// File: rtl/esp32_rom_loader_pkg.sv
// Shared types and helpers for the ESP32 SPI-to-SDRAM ROM loader.
// Holds the FSM states, page selectors, FIFO entry layout and mask helpers.
package esp32_loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [7:0] CTRL_PAGE = 8'hFF;
  localparam logic [7:0] CFG_PAGE  = 8'hFE;
  localparam logic [7:0] ROM_PAGE  = 8'h00;

  // Word address only: the byte lane is implied by the data packing.
  typedef struct packed {
    logic [23:1] addr;
    logic [15:0] data;
  } fifo_entry_t;

  // BSRAM size code N -> (1 KiB << N) - 1, saturating at 16 MiB.
  function automatic logic [23:0] ram_mask_from_code(input logic [7:0] code);
    if (code == 8'd0)
      return 24'h000000;
    if (code >= 8'd14)
      return 24'hFFFFFF;
    return (24'd1024 << code[3:0]) - 24'd1;
  endfunction

  // Every bit becomes the OR of itself and all bits above it.
  function automatic logic [23:0] smear_right(input logic [23:0] v);
    logic [23:0] r;
    r[23] = v[23];
    for (int i = 22; i >= 0; i--)
      r[i] = r[i+1] | v[i];
    return r;
  endfunction

endpackage

// File: rtl/esp32_rom_loader_if.sv
// Bus bundle between the SPI byte source / SDRAM mux and the ROM loader.
// The master side drives the SPI bytes and SDRAM busy; the slave side is the loader.
interface esp32_rom_loader_if;
  logic        spi_wr;
  logic [31:0] spi_addr;
  logic [7:0]  spi_data;
  logic        ram_busy;
  logic        load_wr;
  logic [24:0] load_addr;
  logic [15:0] load_data;
  logic        load_done;
  logic [7:0]  rom_type;
  logic [23:0] rom_mask;
  logic [23:0] ram_mask;
  logic        overflow;

  modport master (
    output spi_wr, spi_addr, spi_data, ram_busy,
    input  load_wr, load_addr, load_data, load_done,
    input  rom_type, rom_mask, ram_mask, overflow
  );

  modport slave (
    input  spi_wr, spi_addr, spi_data, ram_busy,
    output load_wr, load_addr, load_data, load_done,
    output rom_type, rom_mask, ram_mask, overflow
  );
endinterface

// File: rtl/esp32_rom_loader_word_fifo.sv
// Small synchronous word FIFO between byte pairing and the SDRAM issue path.
// Push and pop may share a cycle; a push into a full FIFO is accepted only if a pop frees a slot.
module loader_word_fifo
  import esp32_loader_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  fifo_entry_t push_data,
  input  logic        pop,
  output fifo_entry_t pop_data,
  output logic        full,
  output logic        empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = DEPTH[DEPTH_LOG2:0];

  fifo_entry_t           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   cnt;
  logic                  do_push, do_pop;

  assign empty    = (cnt == '0);
  assign full     = (cnt == FULL_CNT);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/esp32_rom_loader.sv
// ESP32 SPI byte writes -> paired 16-bit SDRAM load words, paced against ram_busy.
// Also owns the cartridge config (rom_type, masks) handed to the SNES core.
module esp32_rom_loader
  import esp32_loader_pkg::*;
#(
  parameter int         C_fifo_depth_log2 = 2,
  parameter logic [7:0] C_ctrl_page       = CTRL_PAGE,
  parameter logic [7:0] C_cfg_page        = CFG_PAGE,
  parameter logic [7:0] C_rom_page        = ROM_PAGE
) (
  input logic              clk,
  input logic              reset,
  esp32_rom_loader_if.slave bus
);

  state_t      state, state_n;
  logic        spi_wr_q, evt_q;
  logic [31:0] evt_addr;
  logic [7:0]  evt_data;
  logic [23:0] rom_a;
  logic        ctrl_evt, cfg_evt, rom_evt;

  logic        pend_vld, pend_vld_n;
  logic [23:1] pend_addr, pend_addr_n;
  logic [7:0]  pend_byte, pend_byte_n;
  logic [23:0] max_addr, max_n;
  logic        enter_load;

  logic        push, issue, fifo_full, fifo_empty;
  fifo_entry_t push_entry, pop_entry;
  logic [1:0]  guard_pipe;
  logic        guard;

  logic        load_wr_r, load_done_r, overflow_r;
  logic [24:0] load_addr_r;
  logic [15:0] load_data_r;
  logic [7:0]  rom_type_r;
  logic [23:0] ram_mask_r;

  // Rising edge of the strobe is latched with its address/data and acted on one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spi_wr_q <= 1'b0;
      evt_q    <= 1'b0;
      evt_addr <= '0;
      evt_data <= '0;
    end else begin
      spi_wr_q <= bus.spi_wr;
      evt_q    <= bus.spi_wr & ~spi_wr_q;
      if (bus.spi_wr & ~spi_wr_q) begin
        evt_addr <= bus.spi_addr;
        evt_data <= bus.spi_data;
      end
    end
  end

  assign rom_a    = evt_addr[23:0];
  assign ctrl_evt = evt_q && (evt_addr[31:24] == C_ctrl_page);
  assign cfg_evt  = evt_q && (evt_addr[31:24] == C_cfg_page);
  assign rom_evt  = evt_q && (evt_addr[31:24] == C_rom_page);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    push        = 1'b0;
    push_entry  = '0;
    pend_vld_n  = pend_vld;
    pend_addr_n = pend_addr;
    pend_byte_n = pend_byte;
    max_n       = max_addr;
    enter_load  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (ctrl_evt && evt_data[0]) begin
          state_n    = LOADING;
          enter_load = 1'b1;
          pend_vld_n = 1'b0;
          max_n      = '0;
        end
      end
      LOADING: begin
        if (ctrl_evt && !evt_data[0]) begin
          // Stop: a lone even byte still has to reach SDRAM before DONE.
          state_n = DRAIN;
          if (pend_vld) begin
            push            = 1'b1;
            push_entry.addr = pend_addr;
            push_entry.data = {8'h00, pend_byte};
            pend_vld_n      = 1'b0;
          end
        end else if (rom_evt) begin
          if (!rom_a[0]) begin
            if (pend_vld) begin
              push            = 1'b1;
              push_entry.addr = pend_addr;
              push_entry.data = {8'h00, pend_byte};
            end
            pend_vld_n  = 1'b1;
            pend_addr_n = rom_a[23:1];
            pend_byte_n = evt_data;
          end else begin
            push            = 1'b1;
            push_entry.addr = rom_a[23:1];
            if (pend_vld && pend_addr == rom_a[23:1]) begin
              push_entry.data = {evt_data, pend_byte};
              pend_vld_n      = 1'b0;
            end else begin
              push_entry.data = {evt_data, 8'h00};
            end
          end
          if (rom_a > max_addr) max_n = rom_a;
        end
      end
      DRAIN: begin
        if (fifo_empty && !guard && !bus.ram_busy) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  loader_word_fifo #(
    .DEPTH_LOG2(C_fifo_depth_log2)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_data(push_entry),
    .pop      (issue),
    .pop_data (pop_entry),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Guard masks the controller's busy latency for two cycles after each request.
  assign guard = |guard_pipe;
  assign issue = ((state == LOADING) || (state == DRAIN)) && !fifo_empty
                 && !bus.ram_busy && !guard;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      guard_pipe  <= '0;
      load_wr_r   <= 1'b0;
      load_addr_r <= '0;
      load_data_r <= '0;
      load_done_r <= 1'b0;
      overflow_r  <= 1'b0;
      rom_type_r  <= '0;
      ram_mask_r  <= '0;
      pend_vld    <= 1'b0;
      pend_addr   <= '0;
      pend_byte   <= '0;
      max_addr    <= '0;
    end else begin
      guard_pipe <= issue ? 2'b11 : {guard_pipe[0], 1'b0};
      load_wr_r  <= issue;
      if (issue) begin
        load_addr_r <= {1'b0, pop_entry.addr, 1'b0};
        load_data_r <= pop_entry.data;
      end
      load_done_r <= (state_n == DONE);
      pend_vld    <= pend_vld_n;
      pend_addr   <= pend_addr_n;
      pend_byte   <= pend_byte_n;
      max_addr    <= max_n;
      if (enter_load)
        overflow_r <= 1'b0;
      else if (push && fifo_full && !issue)
        overflow_r <= 1'b1;
      if (cfg_evt) begin
        if (!evt_addr[0]) rom_type_r <= evt_data;
        else              ram_mask_r <= ram_mask_from_code(evt_data);
      end
    end
  end

  assign bus.load_wr   = load_wr_r;
  assign bus.load_addr = load_addr_r;
  assign bus.load_data = load_data_r;
  assign bus.load_done = load_done_r;
  assign bus.rom_type  = rom_type_r;
  assign bus.rom_mask  = smear_right(max_addr);
  assign bus.ram_mask  = ram_mask_r;
  assign bus.overflow  = overflow_r;

endmodule
